// File: rtl/config_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package config_chain_pkg;

    typedef enum logic [2:0] {IDLE, FILL, SHIFT, SET, DONE} state_t;

    // Number of bitstream words needed to cover the whole chain.
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Width of a counter holding values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/config_word_fifo.sv
// Two-entry word buffer with occupancy count; head is valid whenever count != 0.
// Push and pop in the same cycle keep the count; flush empties it synchronously.
module config_word_fifo #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] mem0;
    logic [WORD_W-1:0] mem1;
    logic              wr_ptr;
    logic              rd_ptr;

    assign head = rd_ptr ? mem1 : mem0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) mem1 <= push_data;
                else        mem0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/config_chain_loader.sv
// Serialises a word stream into the config chain (bit k on the line at S+k), then strobes set.
// Input is valid/ready through a 2-entry buffer; readback words are pushed out with no backpressure.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_hard,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              chain_shift_soft,
    output logic              chain_shift_hard,
    output logic              set_soft,
    output logic              set_hard,
    input  logic              chain_return,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int BC_W      = cnt_w(CHAIN_LEN);
    localparam int BW_W      = cnt_w(WORD_W);
    localparam int WC_W      = cnt_w(NUM_WORDS + 1);

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(CHAIN_LEN - 1);
    localparam logic [BW_W-1:0] LAST_WBIT = BW_W'(WORD_W - 1);
    localparam logic [WC_W-1:0] NW        = WC_W'(NUM_WORDS);

    state_t            state, state_n;
    logic              mode_q, mode_n;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
    logic [BW_W-1:0]   wbit, wbit_n;
    logic [WC_W-1:0]   words, words_n;
    logic [WORD_W-1:0] cur_word, cur_word_n;
    logic [WORD_W-1:0] rb_acc, rb_acc_n, rb_word, rb_data_n;
    logic              rb_valid_n;
    logic              bit_n, set_n, ur_n;
    logic              consume, flush;

    logic              accept;
    logic              fifo_empty, word_avail, push, pop;
    logic [WORD_W-1:0] fifo_head, avail_word;
    logic [1:0]        fifo_count, count_n;
    logic              ready_n, busy_n;

    config_word_fifo #(.WORD_W(WORD_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (cfg_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign accept     = cfg_valid && cfg_ready;
    assign fifo_empty = (fifo_count == 2'd0);
    // A word handed over in the very cycle it is needed bypasses the buffer.
    assign word_avail = !fifo_empty || accept;
    assign avail_word = fifo_empty ? cfg_data : fifo_head;
    assign push       = accept && !(consume && fifo_empty);
    assign pop        = consume && !fifo_empty;
    assign count_n    = flush ? 2'd0 : fifo_count + {1'b0, push} - {1'b0, pop};
    assign ready_n    = (state_n == FILL || state_n == SHIFT) && (count_n < 2'd2) && (words_n < NW);
    assign busy_n     = (state_n == FILL || state_n == SHIFT || state_n == SET);

    always_comb begin
        state_n    = state;
        mode_n     = mode_q;
        bit_cnt_n  = bit_cnt;
        wbit_n     = wbit;
        words_n    = words;
        cur_word_n = cur_word;
        rb_acc_n   = rb_acc;
        rb_word    = rb_acc;
        rb_data_n  = '0;
        rb_valid_n = 1'b0;
        bit_n      = 1'b0;
        set_n      = 1'b0;
        ur_n       = underrun;
        consume    = 1'b0;
        flush      = 1'b0;
        if (accept) words_n = words + WC_W'(1);

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    state_n  = FILL;
                    mode_n   = mode_hard;
                    ur_n     = 1'b0;
                    words_n  = '0;
                    rb_acc_n = '0;
                    flush    = 1'b1;
                end
            end
            FILL: begin
                if (word_avail) begin
                    consume    = 1'b1;
                    state_n    = SHIFT;
                    bit_cnt_n  = '0;
                    wbit_n     = '0;
                    bit_n      = avail_word[0];
                    cur_word_n = avail_word >> 1;
                end
            end
            SHIFT: begin
                rb_word[wbit] = chain_return;
                if (wbit == LAST_WBIT || bit_cnt == LAST_BIT) begin
                    rb_valid_n = 1'b1;
                    rb_data_n  = rb_word;
                    rb_acc_n   = '0;
                end else begin
                    rb_acc_n = rb_word;
                end

                if (bit_cnt == LAST_BIT) begin
                    state_n = SET;
                    set_n   = 1'b1;
                end else if (wbit == LAST_WBIT) begin
                    if (word_avail) begin
                        consume    = 1'b1;
                        bit_n      = avail_word[0];
                        cur_word_n = avail_word >> 1;
                        wbit_n     = '0;
                        bit_cnt_n  = bit_cnt + BC_W'(1);
                    end else begin
                        state_n = IDLE;
                        ur_n    = 1'b1;
                    end
                end else begin
                    bit_n      = cur_word[0];
                    cur_word_n = cur_word >> 1;
                    wbit_n     = wbit + BW_W'(1);
                    bit_cnt_n  = bit_cnt + BC_W'(1);
                end
            end
            SET:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            mode_q           <= 1'b0;
            bit_cnt          <= '0;
            wbit             <= '0;
            words            <= '0;
            cur_word         <= '0;
            rb_acc           <= '0;
            cfg_ready        <= 1'b0;
            chain_shift_soft <= 1'b0;
            chain_shift_hard <= 1'b0;
            set_soft         <= 1'b0;
            set_hard         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            underrun         <= 1'b0;
            rb_data          <= '0;
            rb_valid         <= 1'b0;
        end else begin
            state            <= state_n;
            mode_q           <= mode_n;
            bit_cnt          <= bit_cnt_n;
            wbit             <= wbit_n;
            words            <= words_n;
            cur_word         <= cur_word_n;
            rb_acc           <= rb_acc_n;
            cfg_ready        <= ready_n;
            chain_shift_soft <= bit_n && !mode_n;
            chain_shift_hard <= bit_n && mode_n;
            set_soft         <= set_n && !mode_q;
            set_hard         <= set_n && mode_q;
            busy             <= busy_n;
            done             <= (state == SET);
            underrun         <= ur_n;
            rb_data          <= rb_data_n;
            rb_valid         <= rb_valid_n;
        end
    end

endmodule
